// File: rtl/pwrgood_pkg.sv
// Shared types and sizing helpers for the power-good sequencer.
// Holds the FSM state encoding and default timing constants.
package pwrgood_pkg;

    localparam int unsigned DEF_NUM_RAILS       = 3;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
    localparam int unsigned DEF_STEP_DELAY      = 8;
    localparam int unsigned DEF_TIMEOUT         = 32;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_RAMP   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_ON     = 3'd3,
        ST_DOWN   = 3'd4,
        ST_FAULT  = 3'd5
    } pwrgood_state_e;

    // One counter width covers every timed quantity so all counters saturate alike.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwrgood_if.sv
// Control/status bundle between a power-good sequencer and its rail/host side.
// Level signals only; no handshake or backpressure.
interface pwrgood_if
    import pwrgood_pkg::*;
#(
    parameter int unsigned NUM_RAILS = DEF_NUM_RAILS
);
    logic                 start;
    logic                 stop;
    logic                 clear_fault;
    logic [NUM_RAILS-1:0] rail_ok;
    logic [NUM_RAILS-1:0] rail_en;
    logic                 pwrgood;
    logic                 fault;
    logic                 busy;

    modport master (
        output start, stop, clear_fault, rail_ok,
        input  rail_en, pwrgood, fault, busy
    );

    modport slave (
        input  start, stop, clear_fault, rail_ok,
        output rail_en, pwrgood, fault, busy
    );
endinterface

// File: rtl/pwrgood_debounce.sv
// One rail: 2-flop synchronizer then N-consecutive-sample debounce; db_o moves
// the cycle after the Nth differing sample, fall_o pulses in that same cycle.
module pwrgood_debounce
    import pwrgood_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CW              = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic db_o,
    output logic fall_o
);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    logic          sync1_q, sync2_q;
    logic          db_q, db_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter tracks how long the sample has disagreed with the debounced value.
    always_comb begin
        db_d   = db_q;
        fall_d = 1'b0;
        cnt_d  = cnt_q;
        if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            db_d   = sync2_q;
            fall_d = db_q;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign db_o   = db_q;
    assign fall_o = fall_q;
endmodule

// File: rtl/pwrgood_sequencer.sv
// Ordered rail power-up/down with debounced status, timeout and latched fault.
// Outputs are Moore-decoded from registered state; one cycle from request to effect.
module pwrgood_sequencer
    import pwrgood_pkg::*;
#(
    parameter int unsigned NUM_RAILS       = DEF_NUM_RAILS,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned STEP_DELAY      = DEF_STEP_DELAY,
    parameter int unsigned TIMEOUT         = DEF_TIMEOUT
) (
    input  logic     clk,
    input  logic     rst,
    pwrgood_if.slave ctrl
);
    localparam int unsigned CW = cnt_width(TIMEOUT, STEP_DELAY, DEBOUNCE_CYCLES);
    localparam int unsigned IW = idx_width(NUM_RAILS);

    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] STEP_LAST = CW'(STEP_DELAY - 1);
    localparam logic [IW-1:0] IDX_TOP   = IW'(NUM_RAILS - 1);

    pwrgood_state_e       state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [CW-1:0]        tcnt_q, tcnt_d;
    logic [CW-1:0]        step_q, step_d;
    logic [NUM_RAILS-1:0] ok_db, ok_fall;
    logic [NUM_RAILS-1:0] upto_idx, below_idx, rail_en;
    logic                 rail_fail;

    for (genvar k = 0; k < NUM_RAILS; k++) begin : g_rail
        pwrgood_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CW              (CW)
        ) u_db (
            .clk    (clk),
            .rst    (rst),
            .raw_i  (ctrl.rail_ok[k]),
            .db_o   (ok_db[k]),
            .fall_o (ok_fall[k])
        );
    end

    always_comb begin
        upto_idx  = '0;
        below_idx = '0;
        for (int k = 0; k < int'(NUM_RAILS); k++) begin
            upto_idx[k]  = (k <= int'(idx_q));
            below_idx[k] = (k <  int'(idx_q));
        end
    end

    // In DOWN(i) rail i is already off: only the rails below it stay enabled.
    always_comb begin
        rail_en = '0;
        case (state_q)
            ST_RAMP, ST_SETTLE: rail_en = upto_idx;
            ST_ON:              rail_en = '1;
            ST_DOWN:            rail_en = below_idx;
            default:            rail_en = '0;
        endcase
    end

    assign rail_fail = |(ok_fall & rail_en);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tcnt_d  = tcnt_q;
        step_d  = step_q;
        case (state_q)
            ST_OFF: begin
                if (ctrl.start && !ctrl.stop) begin
                    state_d = ST_RAMP;
                    idx_d   = '0;
                    tcnt_d  = '0;
                end
            end
            ST_RAMP: begin
                if (tcnt_q != CNT_MAX) tcnt_d = tcnt_q + CW'(1);
                if (rail_fail) begin
                    state_d = ST_FAULT;
                end else if (ctrl.stop) begin
                    state_d = ST_DOWN;
                    step_d  = '0;
                end else if (ok_db[idx_q]) begin
                    state_d = ST_SETTLE;
                    step_d  = '0;
                end else if (tcnt_q >= TO_LAST) begin
                    state_d = ST_FAULT;
                end
            end
            ST_SETTLE: begin
                if (rail_fail) begin
                    state_d = ST_FAULT;
                end else if (ctrl.stop) begin
                    state_d = ST_DOWN;
                    step_d  = '0;
                end else if (step_q >= STEP_LAST) begin
                    step_d = '0;
                    if (idx_q == IDX_TOP) begin
                        state_d = ST_ON;
                    end else begin
                        state_d = ST_RAMP;
                        idx_d   = idx_q + IW'(1);
                        tcnt_d  = '0;
                    end
                end else if (step_q != CNT_MAX) begin
                    step_d = step_q + CW'(1);
                end
            end
            ST_ON: begin
                if (rail_fail) begin
                    state_d = ST_FAULT;
                end else if (ctrl.stop) begin
                    state_d = ST_DOWN;
                    idx_d   = IDX_TOP;
                    step_d  = '0;
                end
            end
            ST_DOWN: begin
                if (step_q >= STEP_LAST) begin
                    step_d = '0;
                    if (idx_q == '0) state_d = ST_OFF;
                    else             idx_d   = idx_q - IW'(1);
                end else if (step_q != CNT_MAX) begin
                    step_d = step_q + CW'(1);
                end
            end
            ST_FAULT: begin
                if (ctrl.clear_fault) begin
                    state_d = ST_OFF;
                    idx_d   = '0;
                    tcnt_d  = '0;
                    step_d  = '0;
                end
            end
            default: state_d = ST_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_OFF;
            idx_q   <= '0;
            tcnt_q  <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tcnt_q  <= tcnt_d;
            step_q  <= step_d;
        end
    end

    assign ctrl.rail_en = rail_en;
    assign ctrl.pwrgood = (state_q == ST_ON);
    assign ctrl.fault   = (state_q == ST_FAULT);
    assign ctrl.busy    = (state_q == ST_RAMP) || (state_q == ST_SETTLE) || (state_q == ST_DOWN);
endmodule

// File: tb/tb_pwrgood_sequencer.sv
// Directed bench for pwrgood_sequencer: cycle-stamped vector table plus a
// couple of hand-written multi-cycle sequences; rail_ok mirrors rail_en.
module tb_pwrgood_sequencer;
    import pwrgood_pkg::*;

    typedef struct {
        int         scn;
        int         cyc;
        bit         drv;
        bit         chk;
        logic       st, sp, cl, rs;
        logic [2:0] mask;
        logic [5:0] exp;   // {rail_en[2:0], pwrgood, fault, busy}
    } vec_t;

    vec_t       tbl[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] rail_mask;

    pwrgood_if #(.NUM_RAILS(3)) bus();

    // The DUT's own synchronizer provides the two-cycle rail response delay.
    assign bus.rail_ok = bus.rail_en & rail_mask;

    pwrgood_sequencer #(
        .NUM_RAILS       (3),
        .DEBOUNCE_CYCLES (4),
        .STEP_DELAY      (8),
        .TIMEOUT         (32)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check6(input string name, input logic [5:0] exp);
        logic [5:0] got;
        got = {bus.rail_en, bus.pwrgood, bus.fault, bus.busy};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got en/pg/flt/busy=%b_%b_%b_%b, want %b_%b_%b_%b", name,
                     got[5:3], got[2], got[1], got[0], exp[5:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    function automatic void add_chk(int scn, int cyc, logic [2:0] en, logic pg, logic f, logic b);
        vec_t v;
        v.scn = scn; v.cyc = cyc; v.drv = 1'b0; v.chk = 1'b1;
        v.st = 1'b0; v.sp = 1'b0; v.cl = 1'b0; v.rs = 1'b0; v.mask = 3'b111;
        v.exp = {en, pg, f, b};
        tbl.push_back(v);
    endfunction

    function automatic void add_drv(int scn, int cyc, logic st, logic sp, logic cl, logic rs,
                                    logic [2:0] mask);
        vec_t v;
        v.scn = scn; v.cyc = cyc; v.drv = 1'b1; v.chk = 1'b0;
        v.st = st; v.sp = sp; v.cl = cl; v.rs = rs; v.mask = mask;
        v.exp = '0;
        tbl.push_back(v);
    endfunction

    task automatic do_reset();
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.clear_fault = 1'b0;
        rail_mask       = 3'b111;
        rst             = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic void build_table();
        // 0: power-up, orderly shutdown, then start+stop together in OFF
        add_chk(0, 0, 3'b000, 0, 0, 0);  add_drv(0, 0, 1, 0, 0, 0, 3'b111);
        add_chk(0, 1, 3'b001, 0, 0, 1);  add_drv(0, 1, 0, 0, 0, 0, 3'b111);
        add_chk(0, 15, 3'b001, 0, 0, 1);
        add_chk(0, 16, 3'b011, 0, 0, 1);
        add_chk(0, 30, 3'b011, 0, 0, 1);
        add_chk(0, 31, 3'b111, 0, 0, 1);
        add_chk(0, 45, 3'b111, 0, 0, 1);
        add_chk(0, 46, 3'b111, 1, 0, 0);
        add_chk(0, 60, 3'b111, 1, 0, 0); add_drv(0, 60, 0, 1, 0, 0, 3'b111);
        add_chk(0, 61, 3'b011, 0, 0, 1); add_drv(0, 61, 0, 0, 0, 0, 3'b111);
        add_chk(0, 68, 3'b011, 0, 0, 1);
        add_chk(0, 69, 3'b001, 0, 0, 1);
        add_chk(0, 76, 3'b001, 0, 0, 1);
        add_chk(0, 77, 3'b000, 0, 0, 1);
        add_chk(0, 84, 3'b000, 0, 0, 1);
        add_chk(0, 85, 3'b000, 0, 0, 0); add_drv(0, 85, 1, 1, 0, 0, 3'b111);
        add_chk(0, 86, 3'b000, 0, 0, 0); add_drv(0, 86, 0, 0, 0, 0, 3'b111);
        add_chk(0, 90, 3'b000, 0, 0, 0);
        // 1: rails never come up -> timeout fault; start ignored in FAULT
        add_chk(1, 0, 3'b000, 0, 0, 0);  add_drv(1, 0, 1, 0, 0, 0, 3'b000);
        add_chk(1, 1, 3'b001, 0, 0, 1);  add_drv(1, 1, 0, 0, 0, 0, 3'b000);
        add_chk(1, 32, 3'b001, 0, 0, 1);
        add_chk(1, 33, 3'b000, 0, 1, 0);
        add_drv(1, 35, 1, 0, 0, 0, 3'b000);
        add_chk(1, 36, 3'b000, 0, 1, 0);
        add_chk(1, 40, 3'b000, 0, 1, 0); add_drv(1, 40, 1, 0, 1, 0, 3'b000);
        add_chk(1, 41, 3'b000, 0, 0, 0); add_drv(1, 41, 0, 0, 0, 0, 3'b000);
        add_chk(1, 42, 3'b000, 0, 0, 0);
        // 2: 3-cycle glitch on rail 1 ignored, sustained drop faults
        add_drv(2, 0, 1, 0, 0, 0, 3'b111);
        add_drv(2, 1, 0, 0, 0, 0, 3'b111);
        add_chk(2, 46, 3'b111, 1, 0, 0);
        add_drv(2, 70, 0, 0, 0, 0, 3'b101);
        add_drv(2, 73, 0, 0, 0, 0, 3'b111);
        add_chk(2, 80, 3'b111, 1, 0, 0);
        add_drv(2, 98, 0, 0, 0, 0, 3'b101);   // synchronized sample low from 100
        add_chk(2, 104, 3'b111, 1, 0, 0);
        add_chk(2, 105, 3'b000, 0, 1, 0);
        add_drv(2, 110, 0, 0, 1, 0, 3'b111);
        add_chk(2, 111, 3'b000, 0, 0, 0); add_drv(2, 111, 0, 0, 0, 0, 3'b111);
        // 3: stop during RAMP(1)
        add_drv(3, 0, 1, 0, 0, 0, 3'b111);
        add_drv(3, 1, 0, 0, 0, 0, 3'b111);
        add_chk(3, 16, 3'b011, 0, 0, 1);
        add_chk(3, 20, 3'b011, 0, 0, 1); add_drv(3, 20, 0, 1, 0, 0, 3'b111);
        add_chk(3, 21, 3'b001, 0, 0, 1); add_drv(3, 21, 0, 0, 0, 0, 3'b111);
        add_chk(3, 28, 3'b001, 0, 0, 1);
        add_chk(3, 29, 3'b000, 0, 0, 1);
        add_chk(3, 36, 3'b000, 0, 0, 1);
        add_chk(3, 37, 3'b000, 0, 0, 0);
        // 4: reset mid-ramp, then a clean restart
        add_drv(4, 0, 1, 0, 0, 0, 3'b111);
        add_drv(4, 1, 0, 0, 0, 0, 3'b111);
        add_chk(4, 31, 3'b111, 0, 0, 1);
        add_drv(4, 35, 0, 0, 0, 1, 3'b111);
        add_chk(4, 36, 3'b000, 0, 0, 0); add_drv(4, 36, 0, 0, 0, 0, 3'b111);
        add_drv(4, 37, 1, 0, 0, 0, 3'b111);
        add_chk(4, 38, 3'b001, 0, 0, 1); add_drv(4, 38, 0, 0, 0, 0, 3'b111);
        add_chk(4, 52, 3'b001, 0, 0, 1);
        add_chk(4, 53, 3'b011, 0, 0, 1);
        add_chk(4, 82, 3'b111, 0, 0, 1);
        add_chk(4, 83, 3'b111, 1, 0, 0);
    endfunction

    task automatic run_table();
        int cur_scn;
        int c;
        cur_scn = -1;
        c       = 0;
        for (int r = 0; r < tbl.size(); r++) begin
            if (tbl[r].scn != cur_scn) begin
                do_reset();
                cur_scn = tbl[r].scn;
                c       = 0;
            end
            while (c < tbl[r].cyc) begin
                tick();
                c++;
            end
            if (tbl[r].chk)
                check6($sformatf("vec%0d(scn%0d,c%0d)", r, tbl[r].scn, tbl[r].cyc), tbl[r].exp);
            if (tbl[r].drv) begin
                bus.start       = tbl[r].st;
                bus.stop        = tbl[r].sp;
                bus.clear_fault = tbl[r].cl;
                rst             = tbl[r].rs;
                rail_mask       = tbl[r].mask;
            end
        end
    endtask

    initial begin
        int n;
        build_table();
        run_table();

        // Power-up latency measured with a bounded wait.
        do_reset();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 1;
        while (!bus.pwrgood && n < 200) begin
            tick();
            n++;
        end
        check_int("pwrgood_latency", n, 46);

        // Rail 0 fall and stop land in the same cycle: fault must win.
        repeat (4) tick();
        rail_mask = 3'b110;
        repeat (6) tick();
        check6("fall_pending_still_on", 6'b111_1_0_0);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check6("fault_beats_stop", 6'b000_0_1_0);
        bus.clear_fault = 1'b1;
        rail_mask       = 3'b111;
        tick();
        bus.clear_fault = 1'b0;
        check6("clear_to_off", 6'b000_0_0_0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
